// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and slot-walking helpers for the mux select sequencer.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    EMPTY = 2'd2
  } state_t;

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic  none;
    slot_t slot;
  } next_slot_t;

  // Lowest enabled slot of a mask; 0 when the mask is empty.
  function automatic slot_t first_slot(input logic [3:0] mask);
    slot_t s;
    s = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) s = slot_t'(i);
    end
    return s;
  endfunction

  // Next enabled slot strictly above cur; none=1 when cur is the last one.
  function automatic next_slot_t next_slot(input logic [3:0] mask, input slot_t cur);
    next_slot_t r;
    r.none = 1'b1;
    r.slot = cur;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        r.none = 1'b0;
        r.slot = slot_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Load handshake plus the mux-facing data/select/strobe bundle.
interface mux_select_sequencer_if;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_data;
  logic [3:0] load_mask;
  logic       in0;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       s0;
  logic       s1;
  logic       slot_valid;
  logic       frame_start;
  logic       frame_done;
  logic       busy;

  modport master (
    output load_valid, load_data, load_mask,
    input  load_ready, in0, in1, in2, in3, s0, s1,
           slot_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  load_valid, load_data, load_mask,
    output load_ready, in0, in1, in2, in3, s0, s1,
           slot_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/mux_4to1.sv
// Downstream 4:1 multiplexer; slot index is {s0,s1}.
module MUX_4to1 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  // Pure combinational select of one data input.
  always_comb begin
    out = in0;
    case ({s0, s1})
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mux_select_sequencer_slot_dwell_counter.sv
// Per-slot dwell counter with current and look-ahead terminal-count flags.
module slot_dwell_counter #(
  parameter int SLOT_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic last,
  output logic last_next
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign last      = (count_q == LAST_COUNT);
  assign last_next = (count_d == LAST_COUNT);

  // Count up within a slot, wrap to zero on the final dwell cycle or when not running.
  always_comb begin
    count_d = '0;
    if (restart) begin
      count_d = '0;
    end else if (enable && !last) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Holds a 4-bit frame on the mux inputs and walks the select through its enabled slots.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SLOT_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_select_sequencer_if.slave  bus
);

  state_t     state_q, state_d;
  slot_t      slot_q, slot_d;
  logic [3:0] data_q, data_d;
  logic [3:0] mask_q, mask_d;
  logic       slot_valid_q, slot_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;

  logic       load_ready;
  logic       accept;
  logic       dwell_last;
  logic       dwell_last_next;
  next_slot_t cur_next;
  next_slot_t fut_next;

  assign cur_next   = next_slot(mask_q, slot_q);
  assign load_ready = rst_n & ((state_q == IDLE) |
                               ((state_q == RUN) & dwell_last & cur_next.none));
  assign accept     = bus.load_valid & load_ready;

  slot_dwell_counter #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (accept),
    .enable    (state_q == RUN),
    .last      (dwell_last),
    .last_next (dwell_last_next)
  );

  // Next-state and look-ahead strobe computation; strobes describe the coming cycle.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (accept) begin
      data_d = bus.load_data;
      mask_d = bus.load_mask;
      if (|bus.load_mask) begin
        state_d = RUN;
        slot_d  = first_slot(bus.load_mask);
      end else begin
        state_d = EMPTY;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (dwell_last) begin
            if (!cur_next.none) begin
              slot_d = cur_next.slot;
            end else begin
              state_d = IDLE;
            end
          end
        end
        EMPTY:   state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    fut_next      = next_slot(mask_d, slot_d);
    slot_valid_d  = (state_d == RUN);
    frame_start_d = accept & (|bus.load_mask);
    frame_done_d  = (state_d == EMPTY) |
                    ((state_d == RUN) & dwell_last_next & fut_next.none);
    busy_d        = (state_d != IDLE);
  end

  // State, held frame and registered strobes; reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      slot_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      slot_valid_q  <= slot_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.in0         = data_q[0];
  assign bus.in1         = data_q[1];
  assign bus.in2         = data_q[2];
  assign bus.in3         = data_q[3];
  assign bus.s0          = slot_q[1];
  assign bus.s1          = slot_q[0];
  assign bus.slot_valid  = slot_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;

endmodule
